// File: rtl/ps2_host_tx_if.sv
// Command-byte handshake and status bundle between a controller and ps2_host_tx.
// The controller owns master; the transmitter owns slave.
interface ps2_host_tx_if;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_ack_err;
    logic       tx_timeout;
    logic       rx_inhibit;

    modport master (
        output tx_valid, tx_data,
        input  tx_ready, tx_done, tx_ack_err, tx_timeout, rx_inhibit
    );

    modport slave (
        input  tx_valid, tx_data,
        output tx_ready, tx_done, tx_ack_err, tx_timeout, rx_inhibit
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, bit shifting on device clock
// falling edges, acknowledge check and transfer timeout on open-drain lines.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 10000,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic         clk,
    input  logic         rst,
    ps2_host_tx_if.slave bus,
    inout  wire          PS2CLK,
    inout  wire          PS2DATA
);
    localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_ACK,
        S_WAIT_IDLE
    } state_e;

    state_e           r_state, w_state_nx;
    logic [INH_W-1:0] r_inh_cnt, w_inh_cnt_nx;
    logic [TMO_W-1:0] r_tmo, w_tmo_nx;
    logic [3:0]       r_bit, w_bit_nx;
    logic [8:0]       r_shift, w_shift_nx;
    logic             r_clk_oe, w_clk_oe_nx;
    logic             r_dat_oe, w_dat_oe_nx;
    logic             r_ack_err, w_ack_err_nx;
    logic             r_done, w_done_nx;
    logic             r_timeout, w_timeout_nx;
    logic             r_ready, r_inhibit;
    logic [1:0]       r_clk_s, r_dat_s;
    logic             r_clk_q;
    logic             w_fall;
    logic             w_tmo_run;

    // Open-drain: only ever pull low or release.
    assign PS2CLK  = r_clk_oe ? 1'b0 : 1'bz;
    assign PS2DATA = r_dat_oe ? 1'b0 : 1'bz;

    assign bus.tx_ready   = r_ready;
    assign bus.tx_done    = r_done;
    assign bus.tx_ack_err = r_ack_err;
    assign bus.tx_timeout = r_timeout;
    assign bus.rx_inhibit = r_inhibit;

    assign w_fall    = r_clk_q & ~r_clk_s[1];
    assign w_tmo_run = (r_state == S_REQ) || (r_state == S_ACK) || (r_state == S_WAIT_IDLE);

    // Two-flop synchronizers plus previous-clock flop for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clk_s <= 2'b11;
            r_dat_s <= 2'b11;
            r_clk_q <= 1'b1;
        end else begin
            r_clk_s <= {r_clk_s[0], PS2CLK};
            r_dat_s <= {r_dat_s[0], PS2DATA};
            r_clk_q <= r_clk_s[1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_inh_cnt <= '0;
            r_tmo     <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_clk_oe  <= 1'b0;
            r_dat_oe  <= 1'b0;
            r_ack_err <= 1'b0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_ready   <= 1'b1;
            r_inhibit <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_inh_cnt <= w_inh_cnt_nx;
            r_tmo     <= w_tmo_nx;
            r_bit     <= w_bit_nx;
            r_shift   <= w_shift_nx;
            r_clk_oe  <= w_clk_oe_nx;
            r_dat_oe  <= w_dat_oe_nx;
            r_ack_err <= w_ack_err_nx;
            r_done    <= w_done_nx;
            r_timeout <= w_timeout_nx;
            r_ready   <= (w_state_nx == S_IDLE);
            r_inhibit <= (w_state_nx != S_IDLE);
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_inh_cnt_nx = r_inh_cnt;
        w_tmo_nx     = r_tmo;
        w_bit_nx     = r_bit;
        w_shift_nx   = r_shift;
        w_clk_oe_nx  = r_clk_oe;
        w_dat_oe_nx  = r_dat_oe;
        w_ack_err_nx = r_ack_err;
        w_done_nx    = 1'b0;
        w_timeout_nx = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_clk_oe_nx = 1'b0;
                w_dat_oe_nx = 1'b0;
                if (bus.tx_valid && r_ready) begin
                    w_state_nx   = S_INHIBIT;
                    w_shift_nx   = {~^bus.tx_data, bus.tx_data};
                    w_inh_cnt_nx = '0;
                    w_bit_nx     = '0;
                    w_ack_err_nx = 1'b0;
                    w_clk_oe_nx  = 1'b1;
                end
            end
            S_INHIBIT: begin
                w_inh_cnt_nx = r_inh_cnt + INH_W'(1);
                // Start bit goes low during the last inhibit cycle.
                if (r_inh_cnt >= INH_W'(INHIBIT_CYCLES - 2)) w_dat_oe_nx = 1'b1;
                if (r_inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
                    w_clk_oe_nx = 1'b0;
                    w_tmo_nx    = '0;
                    w_state_nx  = S_REQ;
                end
            end
            S_REQ: begin
                w_tmo_nx = r_tmo + TMO_W'(1);
                if (w_fall) begin
                    w_bit_nx = r_bit + 4'd1;
                    if (r_bit == 4'd9) begin
                        w_dat_oe_nx = 1'b0;
                        w_state_nx  = S_ACK;
                    end else begin
                        w_dat_oe_nx = ~r_shift[0];
                        w_shift_nx  = {1'b1, r_shift[8:1]};
                    end
                end
            end
            S_ACK: begin
                w_tmo_nx = r_tmo + TMO_W'(1);
                if (w_fall) begin
                    w_ack_err_nx = r_dat_s[1];
                    w_state_nx   = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                w_tmo_nx = r_tmo + TMO_W'(1);
                if (r_clk_s[1] && r_dat_s[1]) begin
                    w_done_nx  = 1'b1;
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase

        // Timeout overrides any completion decided in the same cycle.
        if (w_tmo_run && (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1))) begin
            w_clk_oe_nx  = 1'b0;
            w_dat_oe_nx  = 1'b0;
            w_done_nx    = 1'b0;
            w_timeout_nx = 1'b1;
            w_state_nx   = S_IDLE;
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host and a
// scoreboard compares each received frame against the one queued at send time.
module tb_ps2_host_tx;
    localparam int unsigned INH  = 40;
    localparam int unsigned TMO  = 3000;
    localparam int unsigned HALF = 40;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic dev_clk_low = 1'b0;
    logic dev_dat_low = 1'b0;
    wire  ps2clk;
    wire  ps2data;

    assign ps2clk  = dev_clk_low ? 1'b0 : 1'bz;
    assign ps2data = dev_dat_low ? 1'b0 : 1'bz;
    pullup (ps2clk);
    pullup (ps2data);

    ps2_host_tx_if bus ();

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .PS2CLK (ps2clk),
        .PS2DATA(ps2data)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          t_req = 0;
    int          done_pulses = 0;
    logic [10:0] exp_q[$];

    always @(negedge clk) if (rst && bus.tx_done) done_pulses++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sample point just after the falling clk edge; drives follow the samples.
    task automatic tick();
        @(negedge clk);
        #1;
        cyc++;
    endtask

    task automatic send_frame(input logic [7:0] data, input bit ack, input int n_edges,
                              input bit mid_valid, input bit glitch);
        logic [10:0] got;
        int          low_cnt;
        int          t;
        bit          seen;
        got = '0;
        if (glitch) begin
            dev_clk_low = 1'b1;
            repeat (3) tick();
            dev_clk_low = 1'b0;
            repeat (10) tick();
        end
        if (n_edges == 11) exp_q.push_back({1'b1, ~^data, data, 1'b0});
        chk("ready_idle", 32'(bus.tx_ready), 32'd1);
        bus.tx_data  = data;
        bus.tx_valid = 1'b1;
        if (glitch) dev_clk_low = 1'b1;
        tick();
        chk("clk_low_1cyc", 32'(ps2clk), 32'd0);
        chk("ready_busy", 32'(bus.tx_ready), 32'd0);
        chk("rx_inhibit_on", 32'(bus.rx_inhibit), 32'd1);
        bus.tx_valid = 1'b0;
        dev_clk_low  = 1'b0;
        low_cnt = 1;
        t = 0;
        while (t < int'(INH) + 100) begin
            tick();
            t++;
            if (ps2clk !== 1'b0) break;
            low_cnt++;
        end
        t_req = cyc;
        chk("inhibit_len", 32'(low_cnt), 32'(INH));
        got[0] = ps2data;
        for (int k = 1; k <= n_edges && k <= 10; k++) begin
            repeat (HALF) tick();
            dev_clk_low = 1'b1;
            repeat (HALF) tick();
            got[k] = ps2data;
            dev_clk_low = 1'b0;
            if (mid_valid && k == 4) begin
                bus.tx_data  = 8'hA5;
                bus.tx_valid = 1'b1;
            end
            if (mid_valid && k == 5) bus.tx_valid = 1'b0;
        end
        if (n_edges == 11) begin
            chk("frame", 32'(got), 32'(exp_q.pop_front()));
            repeat (HALF) tick();
            if (ack) dev_dat_low = 1'b1;
            repeat (5) tick();
            dev_clk_low = 1'b1;
            repeat (HALF) tick();
            dev_clk_low = 1'b0;
            dev_dat_low = 1'b0;
            seen = 1'b0;
            t = 0;
            while (t < 200) begin
                tick();
                t++;
                if (bus.tx_done) begin
                    seen = 1'b1;
                    break;
                end
            end
            chk("done_seen", 32'(seen), 32'd1);
            chk("ack_err", 32'(bus.tx_ack_err), 32'(!ack));
            tick();
            chk("done_1cyc", 32'(bus.tx_done), 32'd0);
            chk("ready_back", 32'(bus.tx_ready), 32'd1);
            chk("rx_inhibit_off", 32'(bus.rx_inhibit), 32'd0);
        end
    endtask

    initial begin
        int waited;
        int lows;
        int d0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        repeat (3) tick();
        chk("rst_clk", 32'(ps2clk), 32'd1);
        chk("rst_data", 32'(ps2data), 32'd1);
        chk("rst_ready", 32'(bus.tx_ready), 32'd1);
        chk("rst_done", 32'(bus.tx_done), 32'd0);
        chk("rst_ack_err", 32'(bus.tx_ack_err), 32'd0);
        chk("rst_timeout", 32'(bus.tx_timeout), 32'd0);
        chk("rst_inhibit", 32'(bus.rx_inhibit), 32'd0);
        rst = 1'b1;
        repeat (5) tick();

        send_frame(8'hED, 1'b1, 11, 1'b0, 1'b0);
        send_frame(8'h00, 1'b1, 11, 1'b0, 1'b0);
        send_frame(8'hFF, 1'b1, 11, 1'b0, 1'b0);
        send_frame(8'h01, 1'b1, 11, 1'b0, 1'b0);

        send_frame(8'h5A, 1'b0, 11, 1'b0, 1'b0);
        repeat (20) tick();
        chk("ack_err_hold", 32'(bus.tx_ack_err), 32'd1);
        send_frame(8'hF4, 1'b1, 11, 1'b0, 1'b0);

        send_frame(8'h96, 1'b1, 11, 1'b1, 1'b0);
        lows = 0;
        repeat (30) begin
            tick();
            if (ps2clk === 1'b0) lows++;
        end
        chk("no_requeue", 32'(lows), 32'd0);

        send_frame(8'hC3, 1'b1, 11, 1'b0, 1'b1);

        // Device stops after 5 edges; bit 4 of 0x0F keeps the host pulling data low.
        d0 = done_pulses;
        send_frame(8'h0F, 1'b1, 5, 1'b0, 1'b0);
        chk("data_held_low", 32'(ps2data), 32'd0);
        waited = 0;
        while (!bus.tx_timeout && waited < int'(TMO) + 500) begin
            tick();
            waited++;
        end
        chk("tmo_seen", 32'(bus.tx_timeout), 32'd1);
        chk("tmo_time", 32'(cyc - t_req), 32'(TMO));
        chk("tmo_clk_rel", 32'(ps2clk), 32'd1);
        chk("tmo_data_rel", 32'(ps2data), 32'd1);
        tick();
        chk("tmo_1cyc", 32'(bus.tx_timeout), 32'd0);
        chk("tmo_ready", 32'(bus.tx_ready), 32'd1);
        repeat (300) tick();
        chk("tmo_no_done", 32'(done_pulses - d0), 32'd0);

        // Reset after the 4th bit while the host pulls data low for bit 3 of 0x00.
        send_frame(8'h00, 1'b1, 4, 1'b0, 1'b0);
        tick();
        chk("pre_rst_data", 32'(ps2data), 32'd0);
        rst = 1'b0;
        #1;
        chk("arst_clk", 32'(ps2clk), 32'd1);
        chk("arst_data", 32'(ps2data), 32'd1);
        chk("arst_ready", 32'(bus.tx_ready), 32'd1);
        chk("arst_inhibit", 32'(bus.rx_inhibit), 32'd0);
        chk("arst_done", 32'(bus.tx_done), 32'd0);
        chk("arst_timeout", 32'(bus.tx_timeout), 32'd0);
        repeat (3) tick();
        rst = 1'b1;
        repeat (5) tick();

        send_frame(8'hF4, 1'b1, 11, 1'b0, 1'b0);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
